// File: rtl/writeback_stage_pkg.sv
// Shared encodings and the WB pipeline-register layout for the writeback stage.
package writeback_stage_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LH  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LW  = 3'd4;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        align_fault;
  } wb_reg_t;

endpackage

// File: rtl/writeback_stage_load_formatter.sv
// Little-endian load extraction and extension; flags halfword/word accesses that are misaligned.
module writeback_stage_load_formatter
  import writeback_stage_pkg::*;
(
  input  logic [2:0]  load_type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] raw_i,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = raw_i[15:8];
      2'd2:    byte_sel = raw_i[23:16];
      2'd3:    byte_sel = raw_i[31:24];
      default: byte_sel = raw_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
  end

  // Reserved load types behave as LW.
  always_comb begin
    data_o       = raw_i;
    misaligned_o = 1'b0;
    case (load_type_i)
      LD_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: data_o = {24'd0, byte_sel};
      LD_LH: begin
        data_o       = {{16{half_sel[15]}}, half_sel};
        misaligned_o = addr_lo_i[0];
      end
      LD_LHU: begin
        data_o       = {16'd0, half_sel};
        misaligned_o = addr_lo_i[0];
      end
      default: begin
        data_o       = raw_i;
        misaligned_o = (addr_lo_i != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with writeback data selection, write suppression and a retire counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [4:0]        mem_dest,
  input  logic [1:0]        mem_wb_sel,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic [DATA_W-1:0] mem_pc_plus8,
  input  logic              stall,
  input  logic              flush,
  output logic [4:0]        WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              wb_valid,
  output logic              align_fault,
  output logic [CNT_W-1:0]  retire_count
);

  wb_reg_t           wb_q, wb_d;
  logic [CNT_W-1:0]  retire_q;
  logic [31:0]       load_fmt;
  logic              load_misaligned;
  logic              misaligned;

  writeback_stage_load_formatter u_fmt (
    .load_type_i  (mem_load_type),
    .addr_lo_i    (mem_addr_lo),
    .raw_i        (mem_load_data),
    .data_o       (load_fmt),
    .misaligned_o (load_misaligned)
  );

  assign misaligned = (mem_wb_sel == WB_SEL_LOAD) && load_misaligned;

  always_comb begin
    wb_d.valid       = mem_valid;
    wb_d.reg_write   = mem_reg_write;
    wb_d.dest        = mem_dest;
    wb_d.align_fault = mem_valid && misaligned;
    case (mem_wb_sel)
      WB_SEL_LOAD: wb_d.data = misaligned ? 32'd0 : load_fmt;
      WB_SEL_LINK: wb_d.data = mem_pc_plus8;
      default:     wb_d.data = mem_alu_result;
    endcase
  end

  // Flush only kills validity/fault; the other fields are left as they were.
  always_ff @(posedge clock) begin
    if (Reset) begin
      wb_q     <= '0;
      retire_q <= '0;
    end else if (flush) begin
      wb_q.valid       <= 1'b0;
      wb_q.align_fault <= 1'b0;
    end else if (!stall) begin
      wb_q <= wb_d;
      if (mem_valid && !misaligned)
        retire_q <= retire_q + CNT_W'(1);
    end
  end

  assign WriteReg     = wb_q.dest;
  assign WriteData    = wb_q.data;
  assign wb_valid     = wb_q.valid;
  assign align_fault  = wb_q.align_fault;
  assign retire_count = retire_q;

  // Reset gating keeps a held write from racing the register file's level-sensitive clear.
  assign RegWrite = wb_q.valid && wb_q.reg_write && (wb_q.dest != REG_ZERO)
                    && !wb_q.align_fault && !Reset;

endmodule
